// File: rtl/risc_rf_pkg.sv
// Shared constants, word/address types and write-port priority helper for the multi-ported register file.
// Pure declarations; no latency or flow control of its own.
package risc_rf_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned NUM_RD_DEF = 4;
  localparam int unsigned NUM_WR_DEF = 2;
  localparam int unsigned AW_DEF     = $clog2(NREGS_DEF);

  // Upper bound on write ports the priority helper can resolve.
  localparam int unsigned MAX_WR   = 8;
  localparam int unsigned WR_IDX_W = $clog2(MAX_WR);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  typedef struct packed {
    logic                vld;
    logic [WR_IDX_W-1:0] idx;
  } wr_sel_t;

  // hit[i] marks write port i as targeting the address of interest; the highest index wins.
  function automatic wr_sel_t wr_winner(input logic [MAX_WR-1:0] hit);
    wr_sel_t sel;
    sel = '0;
    for (int i = 0; i < MAX_WR; i++) begin
      if (hit[i]) begin
        sel.vld = 1'b1;
        sel.idx = WR_IDX_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/risc_rf_scoreboard.sv
// Per-register busy scoreboard: set on long-latency issue, cleared by tagged writeback; set beats clear.
// Updates at posedge, rd_busy is the registered bit (no same-cycle bypass); no backpressure.
module risc_rf_scoreboard
  import risc_rf_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF,
  parameter int unsigned NUM_WR = NUM_WR_DEF,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rset_lg,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  input  logic [NUM_WR-1:0]            wr_clr_busy,
  input  logic                         sb_set,
  input  logic [AW-1:0]                sb_addr,
  output logic [NREGS-1:0]             busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && wr_clr_busy[i] && (wr_addr[i] != '0)) begin
        busy_d[wr_addr[i]] = 1'b0;
      end
    end
    // Applied after the clears: a new producer supersedes the one completing.
    if (sb_set && (sb_addr != '0)) begin
      busy_d[sb_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rset_lg) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rd_busy[j] = busy_q[rd_addr[j]];
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/risc_regfile_mp.sv
// Multi-ported integer register file with optional write-to-read bypass and busy scoreboard; x0 hardwired to 0.
// Reads are combinational (0 cycles), writes land at posedge; no backpressure, issue stalls via rd_busy/busy_vec.
module risc_regfile_mp
  import risc_rf_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF,
  parameter int unsigned NUM_WR = NUM_WR_DEF,
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rset_lg,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]  rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data,
  input  logic [NUM_WR-1:0]            wr_clr_busy,
  input  logic                         sb_set,
  input  logic [AW-1:0]                sb_addr,
  output logic [NREGS-1:0]             busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Later ports overwrite earlier ones, so the highest index wins a conflict.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wr_en[i] && (wr_addr[i] != '0)) begin
        regs_d[wr_addr[i]] = wr_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rset_lg) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  logic [MAX_WR-1:0] hit;
  wr_sel_t           sel;

  // Bypass is suppressed during reset so a held reset reads as all zeros.
  always_comb begin
    rd_data = '0;
    hit     = '0;
    sel     = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      hit = '0;
      for (int i = 0; i < NUM_WR; i++) begin
        hit[i] = wr_en[i] && (wr_addr[i] == rd_addr[j]) && (rd_addr[j] != '0) && !rset_lg;
      end
      sel        = wr_winner(hit);
      rd_data[j] = regs_q[rd_addr[j]];
      if (BYPASS && sel.vld) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (sel.idx == WR_IDX_W'(i)) begin
            rd_data[j] = wr_data[i];
          end
        end
      end
    end
  end

  risc_rf_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rset_lg     (rset_lg),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_clr_busy (wr_clr_busy),
    .sb_set      (sb_set),
    .sb_addr     (sb_addr),
    .busy_vec    (busy_vec)
  );

endmodule

// File: doc/risc_regfile_mp.md
Name: risc_regfile_mp

Overview:
- Parametrised, multi-ported successor to the single-core integer register file.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with optional write-to-read bypass.
- Adds a per-register busy scoreboard so the issue stage can stall on pending multi-cycle results such as loads and divides.
- Sits between decode/issue and the ALU/LSU writeback paths of the dual-issue core.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two and at least 2.
- NUM_RD, 4, number of read ports.
- NUM_WR, 2, number of write ports.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads; when 0 reads return the stored value only.
- AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rset_lg  in  1  synchronous reset, active-high.
- rd_addr  in  NUM_RD x AW  read addresses.
- rd_data  out  NUM_RD x XLEN  read data.
- rd_busy  out  NUM_RD  scoreboard busy bit of each read address.
- wr_en  in  NUM_WR  write enables.
- wr_addr  in  NUM_WR x AW  write addresses.
- wr_data  in  NUM_WR x XLEN  write data.
- wr_clr_busy  in  NUM_WR  when 1, a write also clears the busy bit of wr_addr.
- sb_set  in  1  issue of a long-latency op: mark sb_addr busy.
- sb_addr  in  AW  destination register of the long-latency op.
- busy_vec  out  NREGS  full scoreboard, for debug and stall logic.

Behaviour:
- Reset: when rset_lg=1 at posedge, all registers are set to 0 and all busy bits to 0; writes and sets in that cycle are ignored. With rset_lg held, rd_data=0 and rd_busy=0 from the next cycle on.
- Register 0 is hardwired: it always reads 0 and is never busy. Writes and sb_set targeting address 0 are dropped, including for bypass.
- Write: if wr_en[i]=1 and wr_addr[i]!=0, the register takes wr_data[i] at posedge; the new value is visible to non-bypassed reads one cycle later.
- Write conflict: if several enabled ports target the same address, the highest port index wins, both for storage and for bypass.
- Read latency is 0, purely combinational from rd_addr.
- With BYPASS=1, rd_data[j] is the wr_data of the winning enabled port whose address equals rd_addr[j] (address nonzero); otherwise the stored value.
- With BYPASS=0, rd_data[j] is always the stored value, i.e. the old value during a same-cycle write.
- Scoreboard set: sb_set=1 with sb_addr!=0 sets busy[sb_addr] at posedge.
- Scoreboard clear: wr_en[i]=1, wr_clr_busy[i]=1 and wr_addr[i]!=0 clear busy[wr_addr[i]] at posedge.
- Set and clear on the same address in the same cycle: set wins, so busy is 1 (the new producer supersedes the old one).
- A write with wr_clr_busy=0 leaves busy unchanged.
- rd_busy[j] = busy[rd_addr[j]], the registered value with no bypass of that cycle's set or clear. busy_vec[0] is always 0.
- No internal state machine beyond storage and scoreboard; all sequential updates are single-cycle.

Decomposition:
- Package risc_rf_pkg holds:
  - the default XLEN, NREGS, NUM_RD and NUM_WR constants;
  - typedefs reg_addr_t (AW bits) and xword_t (XLEN bits);
  - a function that resolves the winning write port for a given address.
- Sub-module risc_rf_scoreboard holds the busy vector plus its set/clear/priority logic. Instantiated once, it can be verified standalone.
- The storage array and read/bypass muxing stay in the top module.

Test Plan:
1. Reset: fill x1..x31 with nonzero values, then hold rset_lg=1 for 1 cycle -> all rd_data=0, busy_vec=0 on the next cycle.
2. x0 protection: wr_en[0]=1, wr_addr=0, wr_data=32'hDEADBEEF, plus sb_set with sb_addr=0 -> x0 reads 0 and busy_vec[0]=0.
3. Bypass: write x5=32'h1234_5678 while rd_addr[0]=5 -> same cycle rd_data[0]=32'h12345678 with BYPASS=1, and the old value 0 with BYPASS=0.
4. Port conflict: port0 writes x7=32'hAAAA_AAAA and port1 writes x7=32'h5555_5555 in the same cycle -> x7 reads 32'h55555555, including bypass.
5. Scoreboard: sb_set x9 -> rd_busy=1 next cycle. Then write x9=32'h42 with wr_clr_busy=1 -> busy=0 next cycle, data 32'h42.
6. Simultaneous set and clear on x9 -> busy stays 1. Then reset mid-pending -> busy clears and x9 reads 0.
